// File: rtl/dmem_sized.sv
// Byte-addressed little-endian data memory with sized loads/stores, a valid/ready request port,
// a one-cycle registered response, access-fault flagging and a post-reset clear engine.
module dmem_sized #(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  SYS_reset_n,
    input  logic                  DMEM_req_valid,
    output logic                  DMEM_req_ready,
    input  logic                  DMEM_mem_write,
    input  logic [1:0]            DMEM_size,
    input  logic                  DMEM_unsigned,
    input  logic [ADDR_WIDTH-1:0] DMEM_address,
    input  logic [31:0]           DMEM_data_in,
    output logic                  DMEM_rsp_valid,
    output logic [31:0]           DMEM_data_out,
    output logic                  DMEM_error
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    // Address bits that may legally be set: word index plus byte lane.
    localparam logic [ADDR_WIDTH-1:0] InRangeMask =
        ADDR_WIDTH'((64'd1 << (IdxW + 2)) - 64'd1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   clr_idx_q, clr_idx_d;
    logic [31:0]       mem [DEPTH];

    logic              rsp_valid_q;
    logic [31:0]       data_out_q;
    logic              error_q;

    logic              accept;
    logic              req_err;
    logic              wr_en;
    logic [IdxW-1:0]   word_idx;
    logic [1:0]        lane;
    logic [3:0]        byte_en;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;

    assign DMEM_req_ready = (state_q == StRun);
    assign accept         = DMEM_req_valid && DMEM_req_ready;
    assign word_idx       = DMEM_address[IdxW+1:2];
    assign lane           = DMEM_address[1:0];

    always_comb begin
        req_err = 1'b0;
        if (DMEM_size == 2'b11) req_err = 1'b1;
        if (DMEM_size == 2'b01 && lane[0]) req_err = 1'b1;
        if (DMEM_size == 2'b10 && lane != 2'b00) req_err = 1'b1;
        if (|(DMEM_address & ~InRangeMask)) req_err = 1'b1;
    end

    assign wr_en = accept && DMEM_mem_write && !req_err;

    always_comb begin
        byte_en = 4'b0000;
        wr_data = DMEM_data_in;
        unique case (DMEM_size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{DMEM_data_in[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{DMEM_data_in[15:0]}};
            end
            2'b10: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word  = mem[word_idx];
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        unique case (DMEM_size)
            2'b00:   load_val = {{24{rd_byte[7] & ~DMEM_unsigned}}, rd_byte};
            2'b01:   load_val = {{16{rd_half[15] & ~DMEM_unsigned}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IdxW'(DEPTH - 1)) state_d = StRun;
            end
            StRun:   state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!SYS_reset_n) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StRun;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Array has no reset of its own; the clear engine zeroes it word by word.
    always_ff @(posedge clk) begin
        if (SYS_reset_n) begin
            if (state_q == StClear) begin
                mem[clr_idx_q] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!SYS_reset_n) begin
            rsp_valid_q <= 1'b0;
            data_out_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            error_q     <= accept && req_err;
            data_out_q  <= (accept && !req_err && !DMEM_mem_write) ? load_val : 32'h0;
        end
    end

    assign DMEM_rsp_valid = rsp_valid_q;
    assign DMEM_data_out  = data_out_q;
    assign DMEM_error     = error_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: expected responses are queued when a request is
// driven and checked when the response pulse appears.
module tb_dmem_sized;

    logic        clk = 1'b0;
    logic        SYS_reset_n;
    logic        DMEM_req_valid;
    logic        DMEM_req_ready;
    logic        DMEM_mem_write;
    logic [1:0]  DMEM_size;
    logic        DMEM_unsigned;
    logic [31:0] DMEM_address;
    logic [31:0] DMEM_data_in;
    logic        DMEM_rsp_valid;
    logic [31:0] DMEM_data_out;
    logic        DMEM_error;

    int total = 0;
    int bad   = 0;
    int rsp_cnt = 0;
    logic [31:0] exp_data_q [$];
    logic        exp_err_q  [$];

    always #5 clk = ~clk;

    dmem_sized #(
        .DEPTH(256),
        .ADDR_WIDTH(32),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .SYS_reset_n(SYS_reset_n),
        .DMEM_req_valid(DMEM_req_valid),
        .DMEM_req_ready(DMEM_req_ready),
        .DMEM_mem_write(DMEM_mem_write),
        .DMEM_size(DMEM_size),
        .DMEM_unsigned(DMEM_unsigned),
        .DMEM_address(DMEM_address),
        .DMEM_data_in(DMEM_data_in),
        .DMEM_rsp_valid(DMEM_rsp_valid),
        .DMEM_data_out(DMEM_data_out),
        .DMEM_error(DMEM_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (DMEM_rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (exp_data_q.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                check("rsp_data", DMEM_data_out, exp_data_q.pop_front());
                check("rsp_err", {31'd0, DMEM_error}, {31'd0, exp_err_q.pop_front()});
            end
        end
    end

    // Called at a negedge; drives one request and returns at the next negedge.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] din,
                        input logic [31:0] exp_d, input logic exp_e);
        DMEM_req_valid = 1'b1;
        DMEM_mem_write = we;
        DMEM_size      = sz;
        DMEM_unsigned  = uns;
        DMEM_address   = addr;
        DMEM_data_in   = din;
        exp_data_q.push_back(exp_d);
        exp_err_q.push_back(exp_e);
        @(negedge clk);
    endtask

    task automatic idle();
        DMEM_req_valid = 1'b0;
        DMEM_mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_not_ready(output int n);
        n = 0;
        while (DMEM_req_ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int base;
        SYS_reset_n    = 1'b0;
        DMEM_req_valid = 1'b0;
        DMEM_mem_write = 1'b0;
        DMEM_size      = 2'b10;
        DMEM_unsigned  = 1'b0;
        DMEM_address   = '0;
        DMEM_data_in   = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {31'd0, DMEM_rsp_valid}, 32'd0);
        check("reset_data_out", DMEM_data_out, 32'd0);
        check("reset_error", {31'd0, DMEM_error}, 32'd0);
        check("reset_ready", {31'd0, DMEM_req_ready}, 32'd0);
        SYS_reset_n = 1'b1;
        count_not_ready(n);
        check("clear_cycles", n, 256);

        send(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0000_0000, 1'b0);
        // Byte access
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        send(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0011, 1'b0);
        send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0000_0044, 1'b0);
        send(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0080, 32'h0, 1'b0);
        send(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
        send(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_0080, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122_8044, 1'b0);
        // Half access
        send(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0);
        send(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF_BEEF, 1'b0);
        send(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000_BEEF, 1'b0);
        send(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'hBEEF_0000, 1'b0);
        idle();
        // Faulting accesses leave memory untouched
        send(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        send(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_FFFF, 32'h0, 1'b1);
        send(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1);
        send(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b1);
        send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122_8044, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();
        // Back-to-back
        base = rsp_cnt;
        send(1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5_A5A5, 32'h0, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hA5A5_A5A5, 1'b0);
        send(1'b1, 2'b00, 1'b0, 32'h30, 32'h0000_0000, 32'h0, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hA5A5_A500, 1'b0);
        idle();
        check("b2b_rsp_count", rsp_cnt - base, 4);
        check("b2b_drained", exp_data_q.size(), 0);

        // Reset in the middle of the clear sweep
        SYS_reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        SYS_reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("midclear_not_ready", {31'd0, DMEM_req_ready}, 32'd0);
        SYS_reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        SYS_reset_n = 1'b1;
        count_not_ready(n);
        check("midclear_restart", n, 256);

        // Reset during streaming traffic
        send(1'b1, 2'b10, 1'b0, 32'h30, 32'h1234_5678, 32'h0, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h1234_5678, 1'b0);
        DMEM_mem_write = 1'b1;
        DMEM_data_in   = 32'hFFFF_FFFF;
        SYS_reset_n    = 1'b0;
        @(negedge clk);
        check("rst_drops_rsp", {31'd0, DMEM_rsp_valid}, 32'd0);
        check("rst_queue_empty", exp_data_q.size(), 0);
        DMEM_req_valid = 1'b0;
        DMEM_mem_write = 1'b0;
        @(negedge clk);
        SYS_reset_n = 1'b1;
        count_not_ready(n);
        check("traffic_reset_clear", n, 256);
        send(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        idle();
        idle();
        check("final_drained", exp_data_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
Parametrised successor of the single-cycle word data memory. It is a byte-addressed, little-endian data memory with byte, halfword and word loads and stores, sign or zero extension on loads, and a valid/ready request port with a registered one-cycle response. It flags misaligned, illegal-size and out-of-range accesses instead of performing them. After reset, a built-in clear engine zeroes the array before the block accepts traffic. It sits in the CPU memory stage in place of the word-only memory.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of two and at least 4.
ADDR_WIDTH, 32, width of the byte address input.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear and leave contents undefined.

Ports:
clk  in  1  clock; all state changes on the rising edge.
SYS_reset_n  in  1  synchronous, active-low reset.
DMEM_req_valid  in  1  a request is present.
DMEM_req_ready  out  1  block can accept a request this cycle.
DMEM_mem_write  in  1  1 = store, 0 = load.
DMEM_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
DMEM_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
DMEM_address  in  ADDR_WIDTH  byte address.
DMEM_data_in  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
DMEM_rsp_valid  out  1  one-cycle response pulse.
DMEM_data_out  out  32  load result, extended to 32 bits; 0 for stores and errors.
DMEM_error  out  1  valid only with rsp_valid; 1 = request was rejected.

Behaviour:
- Reset: when SYS_reset_n=0 at a clock edge:
  - rsp_valid=0, data_out=0, error=0.
  - FSM goes to CLEAR with clear index 0; if CLEAR_ON_RESET=0 it goes to RUN.
  - Reset asserted mid-clear restarts the clear from index 0.
  - Reset asserted mid-traffic drops any pending response; the request in that cycle is not performed.
- FSM, state CLEAR:
  - req_ready=0; requests are ignored.
  - One word, data[clear index], is written to 0 per cycle.
  - After word DEPTH-1 is cleared, go to RUN.
  - req_ready therefore rises exactly DEPTH cycles after the first edge with SYS_reset_n=1.
- FSM, state RUN: req_ready=1 constantly; one request is accepted per cycle (valid && ready).
- Addressing:
  - word index = address[log2(DEPTH)+1:2]; byte lane = address[1:0].
  - Byte b sits in bits [8b+7:8b] (little-endian).
- Error checks, evaluated at accept:
  - size=11.
  - half with address[0]=1.
  - word with address[1:0] not equal to 00.
  - any address bit at or above log2(DEPTH)+2 set.
  - On error: no array write; the response carries error=1 and data_out=0.
- Stores write on the accept edge using byte enables:
  - byte: lane address[1:0] gets data_in[7:0].
  - half: lanes {address[1],0} and {address[1],1} get data_in[15:0].
  - word: all lanes.
  - Lanes that are not enabled are unchanged.
- Loads: the array is read at the accept edge. The selected byte or half is extended per DMEM_unsigned and registered into data_out.
- Response: latency 1.
  - In the cycle after the accept, rsp_valid=1 for both loads and stores.
  - Otherwise rsp_valid=0 and data_out/error hold 0.
  - There is no backpressure on the response.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the post-store data.
  - Requests complete in order at one per cycle.
- DMEM_unsigned is ignored for stores and word loads.

Test Plan:
- Reset with DEPTH=256: hold SYS_reset_n=0 for 2 cycles, then release -> req_ready=0 for exactly 256 cycles, then 1. LW 0x40 -> rsp_valid one cycle later, data_out=0x00000000, error=0.
- Byte access: SW 0x11223344 @0x10, LB @0x13 -> 0x00000011; LB @0x10 -> 0x00000044. Then SB 0x80 @0x11:
  - LB @0x11 -> 0xFFFFFF80.
  - LBU @0x11 -> 0x00000080.
  - LW @0x10 -> 0x11228044.
- Half access: SH 0xBEEF @0x22:
  - LH @0x22 -> 0xFFFFBEEF.
  - LHU @0x22 -> 0x0000BEEF.
  - LW @0x20 -> 0xBEEF0000.
- Errors: each of the following -> error=1, data_out=0, and a later LW @0x10 shows 0x11228044 unchanged:
  - LW @0x12.
  - SH @0x11.
  - size=11 @0x10.
  - SW @0x400 (DEPTH*4).
- Back-to-back: hold req_valid high for 4 cycles (SW 0xA5A5A5A5 @0x30, LW @0x30, SB 0x00 @0x30, LW @0x30) -> 4 consecutive rsp_valid pulses; the loads return 0xA5A5A5A5 then 0xA5A5A500.
- Reset mid-operation:
  - Assert SYS_reset_n=0 at clear cycle 100 -> req_ready is held 0 for a full 256 cycles after release.
  - Assert reset during streaming traffic -> rsp_valid=0 on the next edge, and a prior store @0x30 reads back 0 after the new clear.
